vga_sync_decoder: RTL
=====================

# vga_sync_decoder

Receive-side counterpart of the VGA timing generator. Samples an hsync/vsync/video triple in the pixel-clock domain and recovers the active-pixel coordinates. It also measures line length (clocks) and frame length (lines), and declares lock once the timing is stable. It sits on the display-capture/loopback path and is used both as a link monitor and as a self-check for the generator.

## Interface
- H_ACTIVE, 640: expected active pixels per line (o_x range 0..H_ACTIVE-1)
- V_ACTIVE, 480: expected active lines per frame (o_y range 0..V_ACTIVE-1)
- CW, 11: width of period counters and measured totals
- LOCK_FRAMES, 2: consecutive matching full frames required for lock (1..15)

- i_clk  in  1  pixel clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_hsync  in  1  horizontal sync, active-low by default
- i_vsync  in  1  vertical sync, active-low by default
- i_video  in  1  active-video / data-enable, active-high
- o_x  out  10  active pixel index
- o_y  out  10  active line index
- o_de  out  1  registered i_video, aligned with o_x/o_y
- o_line_start  out  1  1-cycle pulse on hsync assert edge
- o_frame_start  out  1  1-cycle pulse on vsync assert edge
- o_h_total  out  CW  last locked line period, in clocks
- o_v_total  out  CW  last locked frame period, in lines
- o_locked  out  1  timing stable
- o_err  out  1  1-cycle pulse on loss of lock

## Operation
- Previous-cycle copies d_h, d_v, d_de are held in flops. hsync assert edge: i_hsync=0 && d_h=1; vsync edge likewise. Reset loads d_h=d_v=1 and d_de=0, so no spurious edge occurs on the first cycle.
- Pixel indexing:
  - o_x: when i_video=1, loads 0 if d_de=0, else o_x+1 (saturates at 1023). Holds while i_video=0.
  - o_y: on the i_video fall, increments. On a vsync edge, loads 0; the vsync edge wins if both occur in the same cycle.
- Line period: hcnt increments every clock, saturating at all-ones. On an hsync edge, h_meas=hcnt+1 and hcnt=0. h_valid is set after the first hsync edge following reset.
- Frame period: vcnt increments on each hsync edge. On a vsync edge, v_meas=vcnt; vcnt then loads 1 if an hsync edge occurs in the same cycle, else 0.
- Lock FSM states: SEARCH, TRACK, LOCKED.
  - SEARCH: on a vsync edge, go to TRACK, clear ref_h, set match=0.
  - TRACK, hsync edge with h_valid: if ref_h=0, load ref_h=h_meas. Else if h_meas≠ref_h, go to SEARCH.
  - TRACK, vsync edge: if match=0 or v_meas≠ref_v, set ref_v=v_meas and match=1. Else increment match.
  - TRACK, match reaches LOCK_FRAMES: go to LOCKED, load o_h_total=ref_h and o_v_total=ref_v.
  - LOCKED: any h_meas≠ref_h or v_meas≠ref_v, or hcnt saturation, goes to SEARCH and pulses o_err.
- o_locked=1 exactly in LOCKED.
- Mid-operation i_rst: all state and outputs return to reset values on the next edge.

## Timing
- Reset values: o_x=0, o_y=0, o_de=0, o_line_start=0, o_frame_start=0, o_h_total=0, o_v_total=0, o_locked=0, o_err=0; FSM=SEARCH, hcnt=vcnt=0.
- All outputs are registered, with 1-clock latency from the sampled inputs.
- The first active pixel of a line gives o_de=1 and o_x=0 one clock after i_video rises.
- o_line_start and o_frame_start assert in the clock after the edge cycle, for one cycle only.
- o_locked rises 1 clock after the vsync edge that completes LOCK_FRAMES matches.
- o_err and the o_locked fall occur in the same cycle.

## Configuration
- VGA_DEC_SYNC_POS_EN defined: syncs are active-high. Edges are i_hsync=1 && d_h=0 (same for vsync), and reset loads d_h=d_v=0.
- Undefined: active-low syncs, as described above.

## Test plan
All scenarios use 800×525 timing:
- hsync low at x=656..751
- vsync low on lines 490..491
- video for x<640, y<480

- Reset, then 4 frames → o_locked rises 1 clk after the 3rd vsync edge. o_h_total=800, o_v_total=525, o_err never pulses.
- Locked; sample the last active pixel of line 479 → o_x=639, o_y=479, o_de=1. First pixel of the next frame → o_x=0, o_y=0.
- Locked; one line stretched to 801 clocks → o_err pulses once, o_locked=0, re-lock occurs after the 3rd following vsync edge.
- Locked; a frame shortened to 524 lines → o_err at that vsync edge. o_v_total stays 525 until re-lock.
- i_rst asserted for 1 clk mid-frame while locked → next clock all outputs are at reset values, and lock is re-acquired normally.
- Build with VGA_DEC_SYNC_POS_EN and inverted syncs → identical results to the first scenario.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates, measures line and
// frame periods, and tracks lock. Define VGA_DEC_SYNC_POS_EN for active-high syncs.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int CW          = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_video,
  output logic [9:0]    o_x,
  output logic [9:0]    o_y,
  output logic          o_de,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic [CW-1:0] o_h_total,
  output logic [CW-1:0] o_v_total,
  output logic          o_locked,
  output logic          o_err
);

`ifdef VGA_DEC_SYNC_POS_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  if (H_ACTIVE < 1 || H_ACTIVE > 1024 || V_ACTIVE < 1 || V_ACTIVE > 1024 ||
      LOCK_FRAMES < 1 || LOCK_FRAMES > 15 || CW < 2) begin : g_bad_params
    $error("vga_sync_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t        state;
  logic          d_h;
  logic          d_v;
  logic          d_de;
  logic          h_valid;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic [CW-1:0] ref_h;
  logic [CW-1:0] ref_v;
  logic [3:0]    match;

  logic          h_edge;
  logic          v_edge;
  logic          hcnt_sat;
  logic          v_new_ref;
  logic [CW-1:0] h_meas;
  logic [CW-1:0] v_meas;
  logic [3:0]    match_new;

  // Measurements are taken combinationally so the edge cycle itself can judge them.
  always_comb begin
    h_edge    = (i_hsync == SYNC_ON) && (d_h != SYNC_ON);
    v_edge    = (i_vsync == SYNC_ON) && (d_v != SYNC_ON);
    hcnt_sat  = &hcnt;
    h_meas    = hcnt + CW'(1);
    v_meas    = vcnt;
    v_new_ref = (match == 4'd0) || (v_meas != ref_v);
    match_new = v_new_ref ? 4'd1 : match + 4'd1;
  end

  // NOTE: every register here uses <= so all updates see the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      d_h           <= ~SYNC_ON;
      d_v           <= ~SYNC_ON;
      d_de          <= 1'b0;
      h_valid       <= 1'b0;
      hcnt          <= '0;
      vcnt          <= '0;
      ref_h         <= '0;
      ref_v         <= '0;
      match         <= 4'd0;
      state         <= SEARCH;
      o_x           <= 10'd0;
      o_y           <= 10'd0;
      o_de          <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_h_total     <= '0;
      o_v_total     <= '0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      d_h           <= i_hsync;
      d_v           <= i_vsync;
      d_de          <= i_video;
      o_de          <= i_video;
      o_line_start  <= h_edge;
      o_frame_start <= v_edge;
      o_err         <= 1'b0;

      if (i_video) begin
        if (!d_de)              o_x <= 10'd0;
        else if (o_x != 10'h3FF) o_x <= o_x + 10'd1;
      end

      if (v_edge)              o_y <= 10'd0;
      else if (!i_video && d_de) o_y <= o_y + 10'd1;

      if (h_edge) begin
        hcnt    <= '0;
        h_valid <= 1'b1;
      end else if (!hcnt_sat) begin
        hcnt <= hcnt + CW'(1);
      end

      if (v_edge)      vcnt <= h_edge ? CW'(1) : '0;
      else if (h_edge) vcnt <= vcnt + CW'(1);

      case (state)
        SEARCH: begin
          if (v_edge) begin
            state <= TRACK;
            ref_h <= '0;
            match <= 4'd0;
          end
        end
        TRACK: begin
          if (h_edge && h_valid && ref_h != '0 && h_meas != ref_h) begin
            state <= SEARCH;
          end else begin
            if (h_edge && h_valid && ref_h == '0) ref_h <= h_meas;
            if (v_edge) begin
              ref_v <= v_meas;
              match <= match_new;
              if (match_new == LOCK_N) begin
                state     <= LOCKED;
                o_locked  <= 1'b1;
                o_h_total <= ref_h;
                o_v_total <= v_meas;
              end
            end
          end
        end
        LOCKED: begin
          if ((h_edge && h_meas != ref_h) || (v_edge && v_meas != ref_v) || hcnt_sat) begin
            state    <= SEARCH;
            o_locked <= 1'b0;
            o_err    <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
